// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the i2c_tgt I2C target.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WD_ACK,
    RDATA,
    RD_ACK,
    IGNORE
  } state_e;

  localparam logic LP_ACK  = 1'b0;
  localparam logic LP_NACK = 1'b1;

  // 3-input majority vote used by the optional glitch filter.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_tgt_sync.sv
// SCL/SDA input conditioning: 2-FF synchronizer, optional 3-sample majority
// filter (I2C_TGT_FILTER_EN), one-cycle SCL edge flags and START/STOP flags.
module i2c_tgt_sync
  import i2c_tgt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_ff_q, sda_ff_q;
  logic       scl_lvl, sda_lvl;
  logic       scl_prev_q, sda_prev_q;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff_q <= '1;
      sda_ff_q <= '1;
    end else begin
      scl_ff_q <= {scl_ff_q[0], scl_i};
      sda_ff_q <= {sda_ff_q[0], sda_i};
    end
  end

`ifdef I2C_TGT_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  // Majority over the last three synchronized samples drops 1-clk glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_ff_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_ff_q[1]};
      scl_flt_q  <= maj3(scl_hist_q);
      sda_flt_q  <= maj3(sda_hist_q);
    end
  end

  assign scl_lvl = scl_flt_q;
  assign sda_lvl = sda_flt_q;
`else
  assign scl_lvl = scl_ff_q[1];
  assign sda_lvl = sda_ff_q[1];
`endif

  // Previous conditioned levels for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
    end
  end

  assign sda_o      = sda_lvl;
  assign scl_rise_o = scl_lvl & ~scl_prev_q;
  assign scl_fall_o = ~scl_lvl & scl_prev_q;
  // SCL must be stably high across the SDA transition.
  assign start_o    = sda_prev_q & ~sda_lvl & scl_lvl & scl_prev_q;
  assign stop_o     = ~sda_prev_q & sda_lvl & scl_lvl & scl_prev_q;

endmodule

// File: rtl/i2c_tgt.sv
// I2C target exposing a byte register file with auto-incrementing pointer.
// Register 0 is read-only and returns P_DEVID. Define I2C_TGT_FILTER_EN to
// enable the input glitch filter inside i2c_tgt_sync.
module i2c_tgt
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]  P_DEV_ADR  = 7'h53,
  parameter logic [7:0]  P_DEVID    = 8'hE5,
  parameter int unsigned P_REG_NUM  = 64,
  parameter int unsigned P_REG_BITS = $clog2(P_REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic                  loc_wr_en,
  input  logic [P_REG_BITS-1:0] loc_wr_adr,
  input  logic [7:0]            loc_wr_dt,
  output logic                  o_wr_stb,
  output logic [P_REG_BITS-1:0] o_wr_adr,
  output logic [7:0]            o_wr_dt,
  output logic                  o_busy
);

  logic sda_lvl, scl_rise, scl_fall, start_flg, stop_flg;

  i2c_tgt_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_flg),
    .stop_o     (stop_flg)
  );

  state_e                state_q, state_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [P_REG_BITS-1:0] ptr_q, ptr_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [P_REG_BITS-1:0] wr_adr_q, wr_adr_d;
  logic [7:0]            wr_dt_q, wr_dt_d;
  logic [7:0]            regs_q [P_REG_NUM];
  logic [7:0]            byte_in, rd_byte;

  assign byte_in = {shreg_q[6:0], sda_lvl};
  assign rd_byte = (ptr_q == '0) ? P_DEVID : regs_q[ptr_q];

  // Next-state logic. In the *_ACK states sda_oe_q doubles as the phase bit:
  // the first SCL fall starts driving the ACK, the second ends it.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    wr_stb_d = 1'b0;
    wr_adr_d = wr_adr_q;
    wr_dt_d  = wr_dt_q;
    if (stop_flg) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_flg) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d  = byte_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (byte_in[7:1] == P_DEV_ADR) begin
              state_d = ADR_ACK;
              rw_d    = byte_in[0];
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        PTR: if (scl_rise) begin
          shreg_d  = byte_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            ptr_d   = byte_in[P_REG_BITS-1:0];
            state_d = PTR_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shreg_d  = byte_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            wr_stb_d = 1'b1;
            wr_adr_d = ptr_q;
            wr_dt_d  = byte_in;
            ptr_d    = ptr_q + P_REG_BITS'(1);
            state_d  = WD_ACK;
          end
        end
        ADR_ACK, PTR_ACK, WD_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~LP_ACK;
            if (state_q == ADR_ACK) busy_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
            if (state_q == ADR_ACK && rw_q) begin
              state_d  = RDATA;
              shreg_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else if (state_q == ADR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
          end else if (scl_fall) begin
            // bitcnt wraps to 0 after the 8th rise
            if (bitcnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == LP_NACK) state_d = IGNORE;
            else                    ptr_d   = ptr_q + P_REG_BITS'(1);
          end else if (scl_fall) begin
            state_d  = RDATA;
            bitcnt_d = '0;
            shreg_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      wr_stb_q <= 1'b0;
      wr_adr_q <= '0;
      wr_dt_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      wr_stb_q <= wr_stb_d;
      wr_adr_q <= wr_adr_d;
      wr_dt_q  <= wr_dt_d;
    end
  end

  // Register file; entry 0 is never written, bus write wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < P_REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < P_REG_NUM; i++) begin
        if (wr_stb_d && wr_adr_d == P_REG_BITS'(i))
          regs_q[i] <= wr_dt_d;
        else if (loc_wr_en && loc_wr_adr == P_REG_BITS'(i))
          regs_q[i] <= loc_wr_dt;
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign o_busy   = busy_q;
  assign o_wr_stb = wr_stb_q;
  assign o_wr_adr = wr_adr_q;
  assign o_wr_dt  = wr_dt_q;

endmodule
